csr_sequencer: RTL

Sequences all accesses to the machine-level CSR unit (`csr`) and arbitrates between two requesters: the core's instruction port (CSRRW/RS/RC, MRET, exceptions) and pending interrupt injection. It drives the CSR unit's `available`/`busy` handshake and captures `read_value`/`fault` in the single cycle they are valid. It returns one response per operation to the core, including trap redirects. It sits between the core control FSM and `csr`.

---
 rtl/csr_sequencer_if.sv | 46 ++++
 rtl/csr_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/csr_sequencer_if.sv
// Core-side and CSR-unit-side signal bundle for csr_sequencer.
// master: the sequencer; slave: core + CSR unit environment.
interface csr_sequencer_if;
  logic        core_req;
  logic        core_ready;
  logic [2:0]  core_op;
  logic [11:0] core_addr;
  logic [31:0] core_wdata;
  logic        irq_allow;
  logic [31:0] irq_pc;
  logic        ext_int_pending;
  logic        sw_int_pending;
  logic        csr_available;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic        csr_busy;
  logic        csr_fault;
  logic [31:0] csr_read_value;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_redirect;
  logic        resp_is_irq;
  logic        timeout_err;

  modport master (
    input  core_req, core_op, core_addr, core_wdata,
    input  irq_allow, irq_pc, ext_int_pending, sw_int_pending,
    input  csr_busy, csr_fault, csr_read_value,
    output core_ready, csr_available, csr_op,
    output csr_addr_exception, csr_write_value,
    output resp_valid, resp_rdata, resp_fault,
    output resp_redirect, resp_is_irq, timeout_err
  );

  modport slave (
    output core_req, core_op, core_addr, core_wdata,
    output irq_allow, irq_pc, ext_int_pending, sw_int_pending,
    output csr_busy, csr_fault, csr_read_value,
    input  core_ready, csr_available, csr_op,
    input  csr_addr_exception, csr_write_value,
    input  resp_valid, resp_rdata, resp_fault,
    input  resp_redirect, resp_is_irq, timeout_err
  );
endinterface

// File: rtl/csr_sequencer.sv
// Arbitrates core CSR ops and interrupt injection onto the CSR unit,
// runs its available/busy handshake and returns one response per op.
module csr_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic           clk,
  input logic           reset_n,
  csr_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_e;

  localparam logic [3:0] LAST = 4'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_irq_q, is_irq_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rfault_q, rfault_d;
  logic        rredir_q, rredir_d;
  logic        rirq_q, rirq_d;
  logic        terr_q, terr_d;
  logic        avail;
  logic        ready;
  logic        irq_take;
  logic        expired;
  logic        redir;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 4'd1;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_irq_d = is_irq_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rfault_d = rfault_q;
    rredir_d = rredir_q;
    rirq_d   = rirq_q;
    terr_d   = terr_q;
    avail    = 1'b0;
    ready    = 1'b0;
    irq_take = bus.irq_allow &
               (bus.ext_int_pending | bus.sw_int_pending);
    expired  = (cnt_q == LAST);
    redir    = (op_q == 3'b000) | (op_q == 3'b001);

    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        ready = ~irq_take;
        if (irq_take) begin
          op_d     = 3'b000;
          addr_d   = bus.ext_int_pending ? 12'h01B : 12'h013;
          wdata_d  = bus.irq_pc;
          is_irq_d = 1'b1;
          state_d  = ISSUE;
        end else if (bus.core_req) begin
          op_d     = bus.core_op;
          addr_d   = bus.core_addr;
          wdata_d  = bus.core_wdata;
          is_irq_d = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        avail = 1'b1;
        if (state_q == ISSUE && bus.csr_busy) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
        end else if (state_q == WAIT && !bus.csr_busy) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.csr_read_value;
          rfault_d = bus.csr_fault;
          rredir_d = redir;
          rirq_d   = is_irq_q;
          state_d  = DRAIN;
          cnt_d    = 4'd0;
        end else if (expired) begin
          // Abort: answer the op with a fault instead of hanging the core
          rvalid_d = 1'b1;
          rdata_d  = 32'd0;
          rfault_d = 1'b1;
          rredir_d = redir;
          rirq_d   = is_irq_q;
          terr_d   = 1'b1;
          state_d  = IDLE;
          cnt_d    = 4'd0;
        end
      end
      DRAIN: begin
        // cnt_q==0 marks the first drain cycle, where busy is stale
        if (cnt_q != 4'd0 && !bus.csr_busy) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (expired) begin
          terr_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 3'd0;
      addr_q   <= 12'd0;
      wdata_q  <= 32'd0;
      is_irq_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rfault_q <= 1'b0;
      rredir_q <= 1'b0;
      rirq_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_irq_q <= is_irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rfault_q <= rfault_d;
      rredir_q <= rredir_d;
      rirq_q   <= rirq_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.core_ready         = ready;
  assign bus.csr_available      = avail;
  assign bus.csr_op             = op_q;
  assign bus.csr_addr_exception = addr_q;
  assign bus.csr_write_value    = wdata_q;
  assign bus.resp_valid         = rvalid_q;
  assign bus.resp_rdata         = rdata_q;
  assign bus.resp_fault         = rfault_q;
  assign bus.resp_redirect      = rredir_q;
  assign bus.resp_is_irq        = rirq_q;
  assign bus.timeout_err        = terr_q;

endmodule
